spi_arb: RTL and testbench
==========================

Name: spi_arb

Overview:
- Two-port round-robin arbiter and sequencer sharing one `spi_mt` 3-wire SPI master between two independent requesters.
- Accepts a read or write command from each requester and issues it to the master as a `start` pulse with stable command fields.
- Tracks transaction completion from the master's chip-select, returns read data, and flags stalled transactions via a timeout.
- Sits between system-side requesters and `spi_mt`; `sclk`/`sdio` are untouched.

Parameters:
- a_width, 16, register address width (matches `spi_mt`)
- d_width, 8, data width (matches `spi_mt`)
- TIMEOUT, 1023, max clk cycles spent in either WAIT state before abort

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 command pending
- req0_rd  input  1  1 = read, 0 = write
- req0_addr  input  a_width  target register address
- req0_wdata  input  d_width  write data (ignored for reads)
- req0_ready  output  1  one-cycle accept pulse
- req0_done  output  1  one-cycle completion pulse
- req0_err  output  1  valid with req0_done; 1 = timeout abort
- req0_rdata  output  d_width  read data, valid with req0_done
- req1_valid, req1_rd, req1_addr, req1_wdata, req1_ready, req1_done, req1_err, req1_rdata: same as requester 0
- m_start  output  1  start pulse to `spi_mt`
- m_r_w  output  2  command to `spi_mt`: 2'b01 write, 2'b10 read, 2'b00 idle
- m_w_addr  output  a_width  write address to master
- m_w_data  output  d_width  write data to master
- m_r_addr  output  a_width  read address to master
- m_r_data  input  d_width  read data from master
- m_cs  input  1  master chip-select, active low

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset: state IDLE; all outputs 0; m_r_w = 2'b00; timeout counter 0; last_grant = 1, so requester 0 wins the first contention. Reset mid-transaction aborts silently: no done pulse. The master shares `rst`.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE:
  - Any valid selects a winner; move to ISSUE next cycle.
  - If only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins.
  - On the transition, latch winner id, rd, addr and wdata.
- ISSUE (1 cycle):
  - Winner's ready = 1 and m_start = 1.
  - m_r_w / address / data driven from latched command and held constant through DONE.
  - Write: m_w_addr = addr, m_w_data = wdata, m_r_addr = 0.
  - Read: m_r_addr = addr, m_w_addr = 0, m_w_data = 0.
  - Next state: WAIT_LOW.
- WAIT_LOW: m_cs == 0 -> WAIT_HIGH.
- WAIT_HIGH: m_cs == 1 -> DONE. On that same cycle, capture m_r_data into the winner's rdata register for reads; writes capture 0.
- Timeout:
  - Counter clears on entry to each WAIT state and increments each cycle there.
  - When count == TIMEOUT and the exit condition is still unmet, go to DONE with err = 1 and rdata = 0.
- DONE (1 cycle):
  - Winner's done = 1; err as computed; rdata valid.
  - last_grant <= winner. Next state: IDLE.
  - m_r_w returns to 2'b00 in IDLE.
- Requester rules:
  - valid and command fields must stay stable until ready.
  - valid may drop only after ready.
  - A requester may reassert valid during its own done cycle; it is considered in the following IDLE cycle.
  - Loser keeps waiting; it wins the next arbitration because last_grant now points at the other requester.
- rdata outputs:
  - Hold their last value until that requester's next done.
  - The non-granted requester's done, err and rdata are unaffected.
- Latency: valid high in IDLE at cycle N -> ready and m_start at N+1 -> done 1 cycle after m_cs rises (minimum turnaround 2 cycles IDLE->IDLE excluding SPI time).
- No queueing: at most one outstanding transaction.

Test Plan:
- Single write: req0 write addr 16'h0012, wdata 8'hA5 -> req0_ready at N+1, m_start 1 cycle, m_r_w = 01, m_w_addr = 0012, m_w_data = A5 held until done; req0_done with err = 0; req1 outputs quiet.
- Read-back (with `spi_s` attached): after the above, req1 read addr 16'h0012 -> m_r_w = 10, m_r_addr = 0012; req1_done with req1_rdata = 8'hA5, err = 0.
- Contention: req0 and req1 both valid out of reset -> req0 served first, then req1 without an idle gap beyond one IDLE cycle; repeat with both continuously valid -> grants strictly alternate 0,1,0,1.
- Fairness: req0 reasserts valid during its done cycle while req1 valid -> req1 granted next.
- Timeout: hold m_cs = 1 after start -> exactly TIMEOUT+1 cycles in WAIT_LOW, then done with err = 1, rdata = 00; next request proceeds normally.
- Reset mid-transaction: assert rst during WAIT_HIGH -> next cycle all outputs 0, m_r_w = 00, no done pulse; a subsequent req1-only request completes normally.

Source files
------------

// File: rtl/spi_arb_if.sv
// rtl/spi_arb_if.sv - requester and spi_mt master signals shared by spi_arb
// slave = arbiter side, master = requesters plus spi_mt (environment side).
interface spi_arb_if #(
  parameter int a_width = 16,
  parameter int d_width = 8
);
  logic               req0_valid;
  logic               req0_rd;
  logic [a_width-1:0] req0_addr;
  logic [d_width-1:0] req0_wdata;
  logic               req0_ready;
  logic               req0_done;
  logic               req0_err;
  logic [d_width-1:0] req0_rdata;

  logic               req1_valid;
  logic               req1_rd;
  logic [a_width-1:0] req1_addr;
  logic [d_width-1:0] req1_wdata;
  logic               req1_ready;
  logic               req1_done;
  logic               req1_err;
  logic [d_width-1:0] req1_rdata;

  logic               m_start;
  logic [1:0]         m_r_w;
  logic [a_width-1:0] m_w_addr;
  logic [d_width-1:0] m_w_data;
  logic [a_width-1:0] m_r_addr;
  logic [d_width-1:0] m_r_data;
  logic               m_cs;

  modport slave (
    input  req0_valid, req0_rd, req0_addr, req0_wdata,
    input  req1_valid, req1_rd, req1_addr, req1_wdata,
    input  m_r_data, m_cs,
    output req0_ready, req0_done, req0_err, req0_rdata,
    output req1_ready, req1_done, req1_err, req1_rdata,
    output m_start, m_r_w, m_w_addr, m_w_data, m_r_addr
  );

  modport master (
    output req0_valid, req0_rd, req0_addr, req0_wdata,
    output req1_valid, req1_rd, req1_addr, req1_wdata,
    output m_r_data, m_cs,
    input  req0_ready, req0_done, req0_err, req0_rdata,
    input  req1_ready, req1_done, req1_err, req1_rdata,
    input  m_start, m_r_w, m_w_addr, m_w_data, m_r_addr
  );
endinterface

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - two-port round-robin arbiter/sequencer in front of spi_mt
// Completion is tracked from the master's chip-select; a stalled wait aborts with err.
module spi_arb #(
  parameter int a_width = 16,
  parameter int d_width = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic     clk,
  input  logic     rst,
  spi_arb_if.slave bus
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               rd_q, rd_d;
  logic [a_width-1:0] addr_q, addr_d;
  logic [d_width-1:0] wdata_q, wdata_d;
  logic               last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [d_width-1:0] rdata0_q, rdata0_d;
  logic [d_width-1:0] rdata1_q, rdata1_d;
  logic               cap_en;
  logic [d_width-1:0] cap_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap_en  = 1'b0;
    cap_val = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // On contention the requester that did not win last time goes first.
          win_d   = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
          rd_d    = win_d ? bus.req1_rd    : bus.req0_rd;
          addr_d  = win_d ? bus.req1_addr  : bus.req0_addr;
          wdata_d = win_d ? bus.req1_wdata : bus.req0_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!bus.m_cs) begin
          cnt_d   = '0;
          state_d = S_WAIT_HIGH;
        end else if (cnt_q == TMAX) begin
          err_d   = 1'b1;
          cap_en  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (bus.m_cs) begin
          cap_en  = 1'b1;
          cap_val = rd_q ? bus.m_r_data : '0;
          state_d = S_DONE;
        end else if (cnt_q == TMAX) begin
          err_d   = 1'b1;
          cap_en  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rdata0_d = (cap_en && !win_q) ? cap_val : rdata0_q;
    rdata1_d = (cap_en &&  win_q) ? cap_val : rdata1_q;
  end

  logic active;
  assign active = (state_q != S_IDLE);

  assign bus.m_start  = (state_q == S_ISSUE);
  assign bus.m_r_w    = !active ? 2'b00 : (rd_q ? 2'b10 : 2'b01);
  assign bus.m_w_addr = (active && !rd_q) ? addr_q  : '0;
  assign bus.m_w_data = (active && !rd_q) ? wdata_q : '0;
  assign bus.m_r_addr = (active &&  rd_q) ? addr_q  : '0;

  assign bus.req0_ready = (state_q == S_ISSUE) && !win_q;
  assign bus.req1_ready = (state_q == S_ISSUE) &&  win_q;
  assign bus.req0_done  = (state_q == S_DONE)  && !win_q;
  assign bus.req1_done  = (state_q == S_DONE)  &&  win_q;
  assign bus.req0_err   = bus.req0_done && err_q;
  assign bus.req1_err   = bus.req1_done && err_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;
endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - self-checking bench for spi_arb
// Emulates spi_mt chip-select timing and an spi_s register file as a simple memory.
module tb_spi_arb;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_arb_if #(.a_width(AW), .d_width(DW)) bus ();

  spi_arb #(.a_width(AW), .d_width(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  bit              pv[2];
  bit              prd[2];
  logic [AW-1:0]   paddr[2];
  logic [DW-1:0]   pwd[2];
  bit              last_g;
  logic [DW-1:0]   rexp[2];
  logic [DW-1:0]   mem [logic [AW-1:0]];

  typedef struct {
    bit            p0;
    bit            p1;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            lo;
    int            hi;
    int            again;
    bit            exp_w;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    bus.req0_valid = pv[0];
    bus.req0_rd    = prd[0];
    bus.req0_addr  = paddr[0];
    bus.req0_wdata = pwd[0];
    bus.req1_valid = pv[1];
    bus.req1_rd    = prd[1];
    bus.req1_addr  = paddr[1];
    bus.req1_wdata = pwd[1];
  endtask

  task automatic post(input int r, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[r]    = 1'b1;
    prd[r]   = rd;
    paddr[r] = a;
    pwd[r]   = d;
    drive_reqs();
  endtask

  task automatic post_rand(input int r);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7));
    post(r, 1'($urandom_range(0, 1)), a, DW'($urandom));
  endtask

  function automatic bit pick();
    if (pv[0] && pv[1]) return !last_g;
    return pv[1];
  endfunction

  function automatic logic [63:0] ctl_vec();
    return 64'({bus.req0_ready, bus.req1_ready, bus.m_start,
                bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err});
  endfunction

  function automatic logic [63:0] cmd_vec();
    return 64'({bus.m_r_w, bus.m_w_addr, bus.m_w_data, bus.m_r_addr});
  endfunction

  // One transaction from arbitration to the following IDLE cycle.
  // lo: cycles after m_start until cs falls; hi: cycles cs stays low.
  // again: 0 drop valid at ready, 1 keep valid, 2 drop and repost during done.
  task automatic serve(input bit w, input int lo, input int hi, input int again);
    bit            r, to;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rval, rise_val;
    logic [63:0]   ecmd;
    int            done_c;
    r = prd[w];
    a = paddr[w];
    d = pwd[w];
    if (!mem.exists(a)) mem[a] = DW'($urandom);
    if (lo > TO + 1) begin
      to = 1'b1;
      done_c = 3 + TO;
    end else if (hi > TO + 1) begin
      to = 1'b1;
      done_c = 3 + lo + TO;
    end else begin
      to = 1'b0;
      done_c = 2 + lo + hi;
    end
    rval     = (r && !to) ? mem[a] : '0;
    rise_val = r ? mem[a] : DW'($urandom);
    ecmd = r ? 64'({2'b10, 16'h0, 8'h0, a}) : 64'({2'b01, a, d, 16'h0});

    @(posedge clk);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      bus.m_cs     = !(c >= 1 + lo && c < 1 + lo + hi);
      bus.m_r_data = (c == 1 + lo + hi) ? rise_val : DW'($urandom);
      chk("ctl", ctl_vec(), 64'({c == 1 && !w, c == 1 && w, c == 1,
                                 c == done_c && !w, c == done_c && w,
                                 c == done_c && !w && to, c == done_c && w && to}));
      chk("cmd", cmd_vec(), ecmd);
      if (c == 1 && again != 1) begin
        pv[w] = 1'b0;
        drive_reqs();
      end
      if (c == done_c) begin
        chk(w ? "rdata1" : "rdata0", 64'(w ? bus.req1_rdata : bus.req0_rdata), 64'(rval));
        chk(w ? "rdata0_hold" : "rdata1_hold", 64'(w ? bus.req0_rdata : bus.req1_rdata),
            64'(rexp[!w]));
        if (again == 2) post_rand(int'(w));
      end
    end
    rexp[w] = rval;
    last_g  = w;
    if (!r && !to) mem[a] = d;
    bus.m_cs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_ctl", ctl_vec(), 64'(0));
    chk("idle_rw", 64'(bus.m_r_w), 64'(0));
  endtask

  vec_t vecs[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 16'h0012, 8'hA5, 3, 8, 0, 0};
    vecs[1]  = '{0, 1, 1, 16'h0012, 8'h00, 2, 5, 0, 1};
    vecs[2]  = '{1, 1, 0, 16'h0040, 8'h3C, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 16'h0000, 8'h00, 4, 2, 0, 1};
    vecs[4]  = '{1, 1, 1, 16'h0040, 8'h00, 1, 3, 1, 0};
    vecs[5]  = '{0, 0, 0, 16'h0000, 8'h00, 2, 1, 1, 1};
    vecs[6]  = '{0, 0, 0, 16'h0000, 8'h00, 1, 2, 1, 0};
    vecs[7]  = '{0, 0, 0, 16'h0000, 8'h00, 3, 3, 0, 1};
    vecs[8]  = '{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0};
    vecs[9]  = '{0, 1, 1, 16'h0012, 8'h00, 2, 2, 0, 1};
    vecs[10] = '{1, 1, 0, 16'h0077, 8'h5A, 2, 2, 2, 0};
    vecs[11] = '{0, 0, 0, 16'h0000, 8'h00, 1, 4, 0, 1};
    vecs[12] = '{0, 0, 0, 16'h0000, 8'h00, 2, 2, 0, 0};
    vecs[13] = '{1, 0, 1, 16'h0012, 8'h00, TO + 2, 1, 0, 0};
    vecs[14] = '{0, 1, 0, 16'h0055, 8'hC3, 2, TO + 2, 0, 1};
    vecs[15] = '{1, 0, 1, 16'h0077, 8'h00, TO + 1, TO + 1, 0, 0};

    pv[0] = 0; pv[1] = 0; prd[0] = 0; prd[1] = 0;
    paddr[0] = '0; paddr[1] = '0; pwd[0] = '0; pwd[1] = '0;
    last_g = 1'b1; rexp[0] = '0; rexp[1] = '0;
    drive_reqs();
    bus.m_cs = 1'b1;
    bus.m_r_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", ctl_vec(), 64'(0));
    chk("rst_cmd", cmd_vec(), 64'(0));
    chk("rst_rdata", 64'({bus.req0_rdata, bus.req1_rdata}), 64'(0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].p0) post(0, vecs[i].rd, vecs[i].addr, vecs[i].wd);
      if (vecs[i].p1) post(1, vecs[i].rd, vecs[i].addr, vecs[i].wd);
      serve(vecs[i].exp_w, vecs[i].lo, vecs[i].hi, vecs[i].again);
    end

    // Reset while the master holds cs low: silent abort, then a clean req1 read.
    post(0, 1'b0, 16'h0033, 8'h99);
    @(posedge clk);
    @(negedge clk);
    chk("rst_seq_ready", ctl_vec(), 64'(7'b1010000));
    pv[0] = 1'b0;
    drive_reqs();
    bus.m_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctl", ctl_vec(), 64'(0));
    chk("rst_mid_cmd", cmd_vec(), 64'(0));
    chk("rst_mid_rdata", 64'({bus.req0_rdata, bus.req1_rdata}), 64'(0));
    @(negedge clk);
    chk("rst_mid_nodone", ctl_vec(), 64'(0));
    rst = 1'b0;
    bus.m_cs = 1'b1;
    last_g = 1'b1; rexp[0] = '0; rexp[1] = '0;
    post(1, 1'b1, 16'h0012, 8'h00);
    serve(1'b1, 2, 3, 0);

    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++)
        if (!pv[r] && $urandom_range(0, 1) == 1) post_rand(r);
      if (!pv[0] && !pv[1]) post_rand(int'($urandom_range(0, 1)));
      serve(pick(), int'($urandom_range(1, TO + 3)), int'($urandom_range(1, TO + 3)),
            int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
